// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer and BER checker for the encoder/channel/Viterbi chain.
// Define VFC_PRBS_EN for a PRBS-7 source instead of the alternating pattern.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN   = 256,
    parameter int TAIL_LEN    = 2,
    parameter int DEC_LATENCY = 20,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             dec_bit_i,
    output logic             enc_bit_o,
    output logic             enc_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] bit_cnt_o
);
    localparam int MAXA = (FRAME_LEN > TAIL_LEN) ? FRAME_LEN : TAIL_LEN;
    localparam int MAXP = (MAXA > DEC_LATENCY) ? MAXA : DEC_LATENCY;
    localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    typedef enum logic [2:0] {IDLE, SEND, TAIL, DRAIN, DONE} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   phase;
    logic [1:0]      dline [DEC_LATENCY];
    logic            src_bit;
    logic            accept;
    logic            kill;
    logic            tap_bit;
    logic            tap_data;

    assign accept   = (state == IDLE) && start_i;
    assign kill     = abort_i && (state != IDLE);
    assign tap_bit  = dline[DEC_LATENCY-1][1];
    assign tap_data = dline[DEC_LATENCY-1][0];

    always_comb begin
        state_n   = state;
        enc_en_o  = (state == SEND) || (state == TAIL);
        enc_bit_o = (state == SEND) && src_bit;
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        unique case (state)
            IDLE:  if (start_i) state_n = SEND;
            SEND:  if (int'(phase) == FRAME_LEN - 1)
                       state_n = (TAIL_LEN == 0) ? DRAIN : TAIL;
            TAIL:  if (int'(phase) == TAIL_LEN - 1) state_n = DRAIN;
            DRAIN: if (int'(phase) == DEC_LATENCY - 1) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_n;
            if (state_n != state || state == IDLE) phase <= '0;
            else phase <= phase + 1'b1;
        end
    end

    // {bit, is_data}; idle cycles naturally shift in zeros
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            for (int i = 0; i < DEC_LATENCY; i++) dline[i] <= 2'b00;
        end else begin
            dline[0] <= {enc_bit_o, state == SEND};
            for (int i = 1; i < DEC_LATENCY; i++) dline[i] <= dline[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_o <= '0;
            bit_cnt_o <= '0;
        end else if (accept) begin
            err_cnt_o <= '0;
            bit_cnt_o <= '0;
        end else if (tap_data) begin
            if (bit_cnt_o != '1) bit_cnt_o <= bit_cnt_o + 1'b1;
            if ((dec_bit_i != tap_bit) && (err_cnt_o != '1))
                err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

`ifdef VFC_PRBS_EN
    logic [6:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst || accept) lfsr <= 7'h7F;
        else if (state == SEND) lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    assign src_bit = lfsr[6];
`else
    assign src_bit = phase[0];
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: loopback, errors, abort,
// reset, saturation and source pattern against a frame-level model.
module tb_viterbi_frame_ctrl;
    localparam int FL  = 8;
    localparam int TL  = 2;
    localparam int L   = 4;
    localparam int W   = 16;
    localparam int SFL = 20;
    localparam int SW  = 4;

    logic clk = 1'b0;
    logic rst, start, abort, dec;
    logic enc_bit, enc_en, busy, done;
    logic [W-1:0] err_cnt, bit_cnt;
    logic s_start, s_abort, s_dec;
    logic s_bit, s_en, s_busy, s_done;
    logic [SW-1:0] s_err, s_cnt;

    int checks = 0;
    int errors = 0;
    bit prbs [64];

    viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LATENCY(L), .CNT_W(W)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .dec_bit_i(dec),
        .enc_bit_o(enc_bit), .enc_en_o(enc_en), .busy_o(busy), .done_o(done),
        .err_cnt_o(err_cnt), .bit_cnt_o(bit_cnt)
    );

    viterbi_frame_ctrl #(.FRAME_LEN(SFL), .TAIL_LEN(TL), .DEC_LATENCY(L), .CNT_W(SW)) u_sat (
        .clk(clk), .rst(rst), .start_i(s_start), .abort_i(s_abort), .dec_bit_i(s_dec),
        .enc_bit_o(s_bit), .enc_en_o(s_en), .busy_o(s_busy), .done_o(s_done),
        .err_cnt_o(s_err), .bit_cnt_o(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit src(input int n);
`ifdef VFC_PRBS_EN
        return prbs[n];
`else
        return bit'(n % 2);
`endif
    endfunction

    task automatic run_frame(input logic [7:0] dmask, input logic [1:0] tmask,
                             input int restart_at, input int abort_at,
                             input int rst_at, input bit abort_with_start);
        int  stop;
        int  last;
        int  dones;
        int  k;
        int  p_bits;
        int  p_errs;
        bit  inj;
        bit  hist [64];
        stop  = (abort_at >= 0) ? abort_at : rst_at;
        last  = FL + TL + L;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int n = 0; n <= last + 2; n++) begin
            hist[n] = enc_bit;
            if (stop >= 0 && n == stop + 1) begin
                p_bits = 0;
                p_errs = 0;
                for (int j = 0; j < FL; j++)
                    if (j + L <= stop && rst_at < 0) begin
                        p_bits++;
                        if (dmask[j]) p_errs++;
                    end
                chk("stop_en", 32'(enc_en), 0);
                chk("stop_bit", 32'(enc_bit), 0);
                chk("stop_busy", 32'(busy), 0);
                chk("stop_done", 32'(done), 0);
                chk("stop_dones", dones, 0);
                chk("stop_bitcnt", 32'(bit_cnt), p_bits);
                chk("stop_errcnt", 32'(err_cnt), p_errs);
                break;
            end
            chk($sformatf("en@%0d", n), 32'(enc_en), 32'(n < FL + TL));
            chk($sformatf("bit@%0d", n), 32'(enc_bit), 32'((n < FL) ? src(n) : 1'b0));
            chk($sformatf("busy@%0d", n), 32'(busy), 32'(n <= last));
            chk($sformatf("done@%0d", n), 32'(done), 32'(n == last));
            if (done) dones++;
            k = n - L;
            if (k >= 0) begin
                inj = (k < FL) ? dmask[k] : ((k < FL + TL) ? tmask[k-FL] : 1'b0);
                dec = hist[k] ^ inj;
            end else begin
                dec = 1'b0;
            end
            start = (n == restart_at);
            abort = (n == abort_at);
            rst   = (n == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        dec   = 1'b0;
        if (stop < 0) begin
            chk("errcnt", 32'(err_cnt), $countones(dmask));
            chk("bitcnt", 32'(bit_cnt), FL);
            chk("dones", dones, 1);
        end
    endtask

    initial begin
        int  sd;
        bit  sh [64];
        int  sat_exp;
        for (int i = 0; i < 64; i++)
            prbs[i] = (i < 7) ? 1'b1 : (prbs[i-7] ^ prbs[i-6]);
        rst = 1'b1; start = 1'b0; abort = 1'b0; dec = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_dec = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(enc_en), 0);
        chk("rst_bit", 32'(enc_bit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_cnt", 32'(bit_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);

        run_frame(8'h00, 2'b00, -1, -1, -1, 1'b0);
        run_frame(8'h24, 2'b01, -1, -1, -1, 1'b0);
        run_frame(8'h00, 2'b11, 3, -1, -1, 1'b0);
        run_frame(8'h00, 2'b00, -1, 3, -1, 1'b0);
        run_frame(8'h00, 2'b00, -1, -1, FL + TL + 1, 1'b0);
        run_frame(8'h81, 2'b00, -1, -1, -1, 1'b0);
        for (int r = 0; r < 4; r++)
            run_frame(8'($urandom), 2'($urandom), -1, -1, -1, bit'($urandom));

        sat_exp = (SFL < (1 << SW) - 1) ? SFL : (1 << SW) - 1;
        sd = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int n = 0; n <= SFL + TL + L + 2; n++) begin
            sh[n] = s_bit;
            s_dec = (n >= L) ? ~sh[n-L] : 1'b0;
            if (s_done) sd++;
            @(negedge clk);
        end
        chk("sat_err", 32'(s_err), sat_exp);
        chk("sat_cnt", 32'(s_cnt), sat_exp);
        chk("sat_dones", sd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
